// File: rtl/rom_burst_reader.sv
// Burst reader for the 64x16 constant ROM: fetches consecutive words and streams them
// in address order through a small FIFO that hides the one-cycle ROM read latency.
module rom_burst_reader #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 7
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       base_addr,
   input  logic [LEN_W-1:0] word_cnt,
   output logic             rom_CEN,
   output logic [5:0]       rom_A,
   input  logic [15:0]      rom_Q,
   output logic [15:0]      dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_r;
   logic [5:0]       addr_r;
   logic [LEN_W-1:0] issue_left_r;
   logic [LEN_W-1:0] out_left_r;
   logic [15:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [1:0]       inflight_r;
   logic             cap_r;

   logic             accept_s;
   logic             room_s;
   logic             issue_s;
   logic             push_s;
   logic             pop_s;
   logic [5:0]       issue_addr_s;
   logic [LEN_W-1:0] issue_left_nxt_s;
   logic [PW-1:0]    rd_ptr_nxt_s;
   logic [CW-1:0]    count_nxt_s;
   logic [15:0]      head_nxt_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FIFO_DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1'b1);
      end
   endfunction

   // Issue decision and next FIFO head; credit uses registered occupancy plus reads in flight
   always_comb begin
      accept_s     = (state_r == ST_IDLE) && start && (word_cnt != {LEN_W{1'b0}});
      room_s       = (count_r + CW'(inflight_r)) < CW'(FIFO_DEPTH);
      issue_s      = room_s && (accept_s ||
                     ((state_r == ST_FETCH) && (issue_left_r != {LEN_W{1'b0}})));
      issue_addr_s = accept_s ? base_addr : addr_r;
      if (accept_s) begin
         issue_left_nxt_s = word_cnt - LEN_W'(issue_s);
      end else if (issue_s) begin
         issue_left_nxt_s = issue_left_r - LEN_W'(1'b1);
      end else begin
         issue_left_nxt_s = issue_left_r;
      end
      push_s       = cap_r;
      pop_s        = dout_valid && dout_ready;
      rd_ptr_nxt_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      count_nxt_s  = count_r + CW'(push_s) - CW'(pop_s);
      if (push_s && ((count_r - CW'(pop_s)) == {CW{1'b0}})) begin
         head_nxt_s = rom_Q;
      end else begin
         head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
      end
   end

   // Burst control FSM driving the ROM port, busy and done
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         addr_r       <= 6'd0;
         issue_left_r <= {LEN_W{1'b0}};
         out_left_r   <= {LEN_W{1'b0}};
         rom_CEN      <= 1'b1;
         rom_A        <= 6'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done         <= 1'b0;
         rom_CEN      <= ~issue_s;
         issue_left_r <= issue_left_nxt_s;
         if (issue_s) begin
            rom_A  <= issue_addr_s;
            addr_r <= issue_addr_s + 6'd1;
         end
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  busy       <= 1'b1;
                  out_left_r <= word_cnt;
                  state_r    <= (issue_left_nxt_s == {LEN_W{1'b0}}) ? ST_DRAIN : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (pop_s) begin
                  out_left_r <= out_left_r - LEN_W'(1'b1);
               end
               if (issue_left_nxt_s == {LEN_W{1'b0}}) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // The final pop ends the burst; done and busy change together on the next cycle
               if (pop_s) begin
                  out_left_r <= out_left_r - LEN_W'(1'b1);
                  if (out_left_r == LEN_W'(1'b1)) begin
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Read-data capture, FIFO storage and the registered stream head
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= 16'h0000;
         end
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         inflight_r <= 2'd0;
         cap_r      <= 1'b0;
         dout       <= 16'h0000;
         dout_valid <= 1'b0;
      end else begin
         cap_r      <= ~rom_CEN;
         inflight_r <= inflight_r + 2'(issue_s) - 2'(push_s);
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rom_Q;
            wr_ptr_r             <= ptr_inc(wr_ptr_r);
         end
         rd_ptr_r   <= rd_ptr_nxt_s;
         count_r    <= count_nxt_s;
         dout_valid <= (count_nxt_s != {CW{1'b0}});
         if (count_nxt_s != {CW{1'b0}}) begin
            dout <= head_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader with a behavioural 64x16 ROM and randomized
// bursts and backpressure; a negedge monitor checks stream data, ROM addresses and done.
module tb_rom_burst_reader;

   localparam int DEPTH = 4;

   logic        CLK;
   logic        rst_n;
   logic        start;
   logic [5:0]  base_addr;
   logic [6:0]  word_cnt;
   logic        rom_CEN;
   logic [5:0]  rom_A;
   logic [15:0] rom_Q;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        busy;
   logic        done;

   logic [15:0] rom [64];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q  [$];
   logic [5:0]  addr_q [$];
   int          len_q  [$];
   int          cur_left = 0;
   int          issued = 0;
   int          popped = 0;
   bit          pending_done = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_dout = 16'h0000;

   rom_burst_reader #(.FIFO_DEPTH(DEPTH), .LEN_W(7)) dut (
      .CLK(CLK), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .word_cnt(word_cnt), .rom_CEN(rom_CEN), .rom_A(rom_A), .rom_Q(rom_Q),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .busy(busy), .done(done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ROM model: data appears the cycle after it samples CEN low
   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) rom_Q <= 16'h0000;
      else if (!rom_CEN) rom_Q <= rom[rom_A];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event expected none at %0t", nm, $time);
   endtask

   // Monitor: compares the stream, ROM addresses, outstanding reads and done against the scoreboard
   always @(negedge CLK) begin
      if (!rst_n) begin
         prev_stall   = 1'b0;
         pending_done = 1'b0;
      end else begin
         if (pending_done || done) begin
            check("done_pulse", 32'(done), 32'(pending_done));
            if (pending_done) check("busy_at_done", 32'(busy), 32'd0);
         end
         pending_done = 1'b0;
         if (prev_stall) begin
            check("hold_valid", 32'(dout_valid), 32'd1);
            check("hold_data", 32'(dout), 32'(prev_dout));
         end
         if (!rom_CEN) begin
            issued++;
            if (addr_q.size() == 0) note_fail("unexpected_read");
            else check("rom_A", 32'(rom_A), 32'(addr_q.pop_front()));
            check("outstanding_le_depth", 32'((issued - popped) > DEPTH), 32'd0);
         end
         if (dout_valid && dout_ready) begin
            popped++;
            if (exp_q.size() == 0) note_fail("unexpected_word");
            else check("dout", 32'(dout), 32'(exp_q.pop_front()));
            if (cur_left == 0 && len_q.size() != 0) cur_left = len_q.pop_front();
            if (cur_left > 0) begin
               cur_left--;
               if (cur_left == 0) pending_done = 1'b1;
            end
         end
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
      end
   end

   task automatic expect_burst(input logic [5:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(rom[(int'(b) + i) % 64]);
         addr_q.push_back(6'((int'(b) + i) % 64));
      end
      len_q.push_back(n);
   endtask

   task automatic do_start(input logic [5:0] b, input logic [6:0] n, input bit accepted);
      @(posedge CLK); #1;
      start = 1'b1; base_addr = b; word_cnt = n;
      if (accepted) expect_burst(b, int'(n));
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      bit ok = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge CLK); #1;
         if (rnd) dout_ready = 1'($urandom_range(0, 1));
         if (exp_q.size() == 0 && !busy && !done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      end
      dout_ready = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cen"},   32'(rom_CEN), 32'd1);
      check({tag, "_addr"},  32'(rom_A), 32'd0);
      check({tag, "_dout"},  32'(dout), 32'd0);
      check({tag, "_valid"}, 32'(dout_valid), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 16'((i * 40503) & 16'hffff) ^ 16'h5a5a;
      rom[0]  = 16'hdcdc; rom[1]  = 16'h34b2; rom[2]  = 16'h8faa;
      rom[62] = 16'hb663; rom[63] = 16'h0ca6;
      rom[48] = 16'h2b7e; rom[49] = 16'h1516; rom[50] = 16'h28ae; rom[51] = 16'hd2a6;
      rom[52] = 16'habf7; rom[53] = 16'h1588; rom[54] = 16'h09cf; rom[55] = 16'h4f3c;
      rom[32] = 16'h1800; rom[33] = 16'h1111;

      rst_n = 1'b0; start = 1'b0; base_addr = 6'd0; word_cnt = 7'd0; dout_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #2;
      check_reset_outputs("reset");
      @(negedge CLK);
      rst_n = 1'b1;

      // Directed latency burst: base 0, three words, consumer always ready
      @(posedge CLK); #1;
      start = 1'b1; base_addr = 6'd0; word_cnt = 7'd3;
      expect_burst(6'd0, 3);
      for (int c = 0; c <= 6; c++) begin
         @(negedge CLK);
         check($sformatf("lat_cen_c%0d", c), 32'(rom_CEN), 32'((c >= 1 && c <= 3) ? 0 : 1));
         check($sformatf("lat_valid_c%0d", c), 32'(dout_valid), 32'((c >= 3 && c <= 5) ? 1 : 0));
         check($sformatf("lat_busy_c%0d", c), 32'(busy), 32'((c >= 1 && c <= 5) ? 1 : 0));
         check($sformatf("lat_done_c%0d", c), 32'(done), 32'((c == 6) ? 1 : 0));
         if (c == 3) check("lat_first_word", 32'(dout), 32'h0000dcdc);
         if (c == 0) begin
            @(posedge CLK); #1;
            start = 1'b0;
         end
      end
      drain(1'b0);

      // Address wrap at the top of the ROM
      do_start(6'd62, 7'd4, 1'b1);
      drain(1'b0);

      // Backpressure: stall 10 cycles, then random ready
      dout_ready = 1'b0;
      do_start(6'd48, 7'd8, 1'b1);
      repeat (10) @(posedge CLK);
      #1;
      check("stall_head", 32'(dout), 32'h00002b7e);
      check("stall_valid", 32'(dout_valid), 32'd1);
      drain(1'b1);

      // Start while busy is ignored; zero-length start is ignored
      do_start(6'd0, 7'd20, 1'b1);
      do_start(6'd16, 7'd2, 1'b0);
      drain(1'b0);
      do_start(6'd5, 7'd0, 1'b0);
      repeat (3) begin
         @(negedge CLK);
         check("zero_cnt_busy", 32'(busy), 32'd0);
         check("zero_cnt_done", 32'(done), 32'd0);
      end

      // Burst longer than the ROM re-reads from address 0
      do_start(6'd60, 7'd70, 1'b1);
      drain(1'b1);

      for (int r = 0; r < 5; r++) begin
         do_start(6'($urandom_range(0, 63)), 7'($urandom_range(1, 127)), 1'b1);
         drain(1'b1);
      end

      // Asynchronous reset in the middle of a burst
      do_start(6'd0, 7'd10, 1'b1);
      repeat (3) @(posedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete(); addr_q.delete(); len_q.delete();
      cur_left = 0; issued = 0; popped = 0;
      @(negedge CLK);
      @(negedge CLK);
      rst_n = 1'b1;
      do_start(6'd32, 7'd2, 1'b1);
      drain(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
